// File: rtl/fsm_flancos_pkg.sv
// fsm_flancos_pkg
// Shared definitions for the SPI edge-sequencing FSM:
//   state_t          - FSM state encoding
//   CLK_DIV_DEFAULT  - default clk cycles per SPI_CLK half-period
//   cnt_width()      - phase-counter width for a given CLK_DIV
//   CNT_W_DEFAULT    - phase-counter width for the default CLK_DIV
package fsm_flancos_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CONV   = 3'd2,
      CLK_LO = 3'd3,
      CLK_HI = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int CLK_DIV_DEFAULT = 2;

   function automatic int cnt_width(input int div);
      return $clog2(div) + 1;
   endfunction

   localparam int CNT_W_DEFAULT = cnt_width(CLK_DIV_DEFAULT);

endpackage

// File: rtl/fsm_flancos_phase_cnt.sv
// fsm_flancos_phase_cnt
// Down-counter timing one SPI_CLK half-period.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (counter cleared)
//   load - reload with CLK_DIV-1 (asserted on the edge entering a phase)
//   term - counter has reached zero: current cycle is the last of the phase
module fsm_flancos_phase_cnt
   import fsm_flancos_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT,
   parameter int CNT_W   = cnt_width(CLK_DIV)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic term
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= RELOAD;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign term = (cnt_reg == '0);

endmodule

// File: rtl/fsm_flancos.sv
// fsm_flancos
// SPI edge sequencer for the shared amplifier/ADC SPI controller.
// A rising edge on Init (while idle) pulses Reg_Rst, optionally pulses
// ADC_Conv (ADC mode), then generates SPI_CLK (2*CLK_DIV clk period,
// 50% duty, starting low) until EdgDone has been seen, finishing with a
// one-cycle Init_Done pulse.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   Init       - start request (0->1 edge starts a transaction)
//   EdgDone    - edge counter reports all SPI edges produced
//   AMP_ADC    - target select latched at start (1 = amplifier, 0 = ADC)
//   ADC_Conv   - ADC conversion-start strobe
//   SPI_CLK    - SPI serial clock
//   Init_Done  - transaction-complete pulse
//   Reg_Rst    - datapath reset strobe
module fsm_flancos
   import fsm_flancos_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic Init,
   input  logic EdgDone,
   input  logic AMP_ADC,
   output logic ADC_Conv,
   output logic SPI_CLK,
   output logic Init_Done,
   output logic Reg_Rst
);

   state_t state_reg, state_next;
   logic   init_q_reg;
   logic   mode_reg;
   logic   edge_seen_reg;
   logic   start;
   logic   in_clk_phase;
   logic   phase_load;
   logic   phase_term;

   assign start        = (state_reg == IDLE) && Init && !init_q_reg;
   assign in_clk_phase = (state_reg == CLK_LO) || (state_reg == CLK_HI);

   // Reload the phase counter on every edge that enters a clock phase,
   // so each low/high phase lasts exactly CLK_DIV cycles.
   assign phase_load = ((state_next == CLK_LO) || (state_next == CLK_HI)) &&
                       (state_next != state_reg);

   fsm_flancos_phase_cnt #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (phase_load),
      .term (phase_term)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         init_q_reg    <= 1'b0;
         mode_reg      <= 1'b0;
         edge_seen_reg <= 1'b0;
      end else begin
         state_reg  <= state_next;
         init_q_reg <= Init;
         if (start) begin
            mode_reg      <= AMP_ADC;
            edge_seen_reg <= 1'b0;
         end else if (in_clk_phase && EdgDone) begin
            // Sticky so a single-cycle EdgDone pulse is never lost.
            edge_seen_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ADC_Conv   = 1'b0;
      SPI_CLK    = 1'b0;
      Init_Done  = 1'b0;
      Reg_Rst    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            Reg_Rst    = 1'b1;
            state_next = mode_reg ? CLK_LO : CONV;
         end
         CONV: begin
            ADC_Conv   = 1'b1;
            state_next = CLK_LO;
         end
         CLK_LO: begin
            if (phase_term) state_next = CLK_HI;
         end
         CLK_HI: begin
            SPI_CLK = 1'b1;
            // The high phase always runs to completion; EdgDone in its
            // final cycle still counts toward finishing now.
            if (phase_term) begin
               state_next = (edge_seen_reg || EdgDone) ? DONE : CLK_LO;
            end
         end
         DONE: begin
            Init_Done  = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fsm_flancos.sv
module tb_fsm_flancos;

   logic clk;
   logic rst;
   logic Init;
   logic EdgDone;
   logic AMP_ADC;
   logic ADC_Conv;
   logic SPI_CLK;
   logic Init_Done;
   logic Reg_Rst;

   fsm_flancos #(.CLK_DIV(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .Init      (Init),
      .EdgDone   (EdgDone),
      .AMP_ADC   (AMP_ADC),
      .ADC_Conv  (ADC_Conv),
      .SPI_CLK   (SPI_CLK),
      .Init_Done (Init_Done),
      .Reg_Rst   (Reg_Rst)
   );

   // Output codes {Reg_Rst, ADC_Conv, SPI_CLK, Init_Done}
   localparam logic [3:0] C_Z = 4'b0000;
   localparam logic [3:0] C_R = 4'b1000;
   localparam logic [3:0] C_C = 4'b0100;
   localparam logic [3:0] C_S = 4'b0010;
   localparam logic [3:0] C_D = 4'b0001;

   typedef struct {
      logic [3:0] code;
      int         len;
      int         cyc;   // -1: start cycle not checked
   } ev_t;

   ev_t exp_q[$];
   int  chk = 0;
   int  err = 0;
   int  cyc = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input logic [3:0] code, input int len, input int c);
      ev_t e;
      e.code = code;
      e.len  = len;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   task automatic check_event(input logic [3:0] code, input int len, input int c);
      ev_t e;
      chk++;
      if (exp_q.size() == 0) begin
         err++;
         $display("FAIL unexpected_run got code=%b len=%0d cyc=%0d required none", code, len, c);
      end else begin
         e = exp_q.pop_front();
         if (code !== e.code || len != e.len || (e.cyc >= 0 && c != e.cyc)) begin
            err++;
            $display("FAIL run got code=%b len=%0d cyc=%0d required code=%b len=%0d cyc=%0d",
                     code, len, c, e.code, e.len, e.cyc);
         end else begin
            $display("run ok code=%b len=%0d cyc=%0d", code, len, c);
         end
      end
   endtask

   // Monitor: compresses the output stream into runs of equal codes.
   // Non-zero runs are always reported; zero runs only when they follow a
   // non-zero run and are short (the SPI_CLK low phases), so idle gaps are
   // not reported.
   initial begin : monitor
      logic [3:0] cur;
      logic [3:0] run_code;
      int         run_len;
      int         run_cyc;
      bit         zero_emit;
      run_code  = C_Z;
      run_len   = 0;
      run_cyc   = 0;
      zero_emit = 1'b0;
      forever begin
         @(negedge clk);
         cur = {Reg_Rst, ADC_Conv, SPI_CLK, Init_Done};
         if (cur === run_code) begin
            run_len++;
         end else begin
            if (run_code != C_Z || (zero_emit && run_len < 8))
               check_event(run_code, run_len, run_cyc);
            zero_emit = (run_code != C_Z);
            run_code  = cur;
            run_len   = 1;
            run_cyc   = cyc;
         end
         if (rst) zero_emit = 1'b0;
      end
   end

   task automatic chk_outputs_zero(input string name);
      logic [3:0] code;
      code = {Reg_Rst, ADC_Conv, SPI_CLK, Init_Done};
      chk++;
      if (code !== C_Z) begin
         err++;
         $display("FAIL %s got %b required 0000", name, code);
      end else begin
         $display("%s ok outputs=%b", name, code);
      end
   endtask

   task automatic rise_init(input logic amp, output int c);
      @(posedge clk);
      #1;
      AMP_ADC = amp;
      Init    = 1'b1;
      c       = cyc;
   endtask

   task automatic wait_spi_rise(input int k);
      int   seen;
      logic prev;
      seen = 0;
      prev = 1'b0;
      for (int i = 0; i < 200 && seen < k; i++) begin
         @(negedge clk);
         if (SPI_CLK && !prev) seen++;
         prev = SPI_CLK;
      end
      chk++;
      if (seen < k) begin
         err++;
         $display("FAIL spi_rise_wait got %0d rises required %0d", seen, k);
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (Init_Done) seen = 1'b1;
      end
      chk++;
      if (!seen) begin
         err++;
         $display("FAIL init_done_wait got no Init_Done required 1");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int c;
      rst     = 1'b1;
      Init    = 1'b1;
      AMP_ADC = 1'b1;
      EdgDone = 1'b1;

      // Reset with Init held high; Init still high at release is a start.
      repeat (2) begin
         @(negedge clk);
         chk_outputs_zero("reset_outputs");
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      c   = cyc;
      push(C_R, 1, c + 1); push(C_Z, 2, -1); push(C_S, 2, -1); push(C_D, 1, -1);
      wait_done();
      Init    = 1'b0;
      EdgDone = 1'b0;
      idle(15);

      // Amplifier write, EdgDone pulsed mid third high phase.
      rise_init(1'b1, c);
      push(C_R, 1, c + 1);
      push(C_Z, 2, -1); push(C_S, 2, -1);
      push(C_Z, 2, -1); push(C_S, 2, -1);
      push(C_Z, 2, -1); push(C_S, 2, -1);
      push(C_D, 1, -1);
      wait_spi_rise(3);
      EdgDone = 1'b1;
      @(negedge clk);
      EdgDone = 1'b0;
      wait_done();
      Init = 1'b0;
      idle(15);

      // ADC read; AMP_ADC flipped after LOAD must be ignored.
      rise_init(1'b0, c);
      push(C_R, 1, c + 1); push(C_C, 1, -1);
      push(C_Z, 2, -1); push(C_S, 2, -1);
      push(C_Z, 2, -1); push(C_S, 2, -1);
      push(C_D, 1, -1);
      repeat (2) @(negedge clk);
      AMP_ADC = 1'b1;
      wait_spi_rise(2);
      EdgDone = 1'b1;
      wait_done();
      EdgDone = 1'b0;
      Init    = 1'b0;
      idle(15);

      // Init held 3 clk with EdgDone already high: one ADC transaction,
      // single high phase.
      EdgDone = 1'b1;
      rise_init(1'b0, c);
      push(C_R, 1, c + 1); push(C_C, 1, -1);
      push(C_Z, 2, -1); push(C_S, 2, -1); push(C_D, 1, -1);
      repeat (3) @(posedge clk);
      #1;
      Init = 1'b0;
      wait_done();
      idle(15);

      // Second rise, amplifier mode.
      rise_init(1'b1, c);
      push(C_R, 1, c + 1); push(C_Z, 2, -1); push(C_S, 2, -1); push(C_D, 1, -1);
      wait_done();
      Init    = 1'b0;
      EdgDone = 1'b0;
      idle(15);

      // Reset during CLK_HI: high phase cut, no Init_Done.
      rise_init(1'b1, c);
      push(C_R, 1, c + 1); push(C_Z, 2, -1); push(C_S, 1, -1);
      wait_spi_rise(1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_outputs_zero("abort_outputs");
      rst  = 1'b0;
      Init = 1'b0;
      idle(15);

      // Fresh rise after the abort is accepted.
      EdgDone = 1'b1;
      rise_init(1'b1, c);
      push(C_R, 1, c + 1); push(C_Z, 2, -1); push(C_S, 2, -1); push(C_D, 1, -1);
      wait_done();
      Init    = 1'b0;
      EdgDone = 1'b0;
      idle(15);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      chk++;
      if (exp_q.size() != 0) begin
         err++;
         $display("FAIL pending_runs got %0d left required 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end

endmodule
